writeback_arbiter: RTL and testbench
====================================

# writeback_arbiter

Merges the two sources of register-file writes in the cached RISC-V core and drives the register file's single write port (WE3/A3/WD3). The two sources are in-order pipeline writebacks (ALU results and cache-hit loads) and late load data returned by the data cache after a miss. The block keeps an in-order queue of destination registers for outstanding misses. It asserts a decode stall while an instruction reads a register whose load data has not yet been written.

## Interface
Parameters:
- WIDTH, 32, data width of register-file writes
- ADDR, 5, register index width
- DEPTH, 2, maximum outstanding load misses (power of two, ≥2)

Ports:
- clk  in  1  core clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- pipe_we  in  1  pipeline writeback valid this cycle
- pipe_rd  in  ADDR  pipeline destination register
- pipe_wd  in  WIDTH  pipeline writeback data
- miss_issue  in  1  a load missed; reserve miss_rd
- miss_rd  in  ADDR  destination of the missing load
- miss_full  out  1  queue holds DEPTH entries; upstream must not issue a miss
- fill_valid  in  1  cache returns data for the oldest outstanding miss
- fill_data  in  WIDTH  returned load data
- fill_ready  out  1  fill accepted this cycle when high with fill_valid
- rs1, rs2  in  ADDR  source registers of the instruction in decode
- stall  out  1  decode must hold
- WE3  out  1  register-file write enable
- A3  out  ADDR  register-file write address
- WD3  out  WIDTH  register-file write data
- err  out  1  sticky protocol-violation flag

## Operation
State:
- Miss queue: circular FIFO of DEPTH rd entries, with rd pointer, wr pointer and count.
- Hold register: {hold_valid, hold_rd, hold_data}.
- Sticky err bit.

Write-port priority, highest first. The write-port outputs are combinational.
- pipe_we with pipe_rd≠0: WE3=1, A3=pipe_rd, WD3=pipe_wd.
- hold_valid: drive the held write, then clear hold_valid at the edge.
- Accepted fill with no pipeline write: drive {queue head rd, fill_data} directly.
- Otherwise WE3=0, A3=0, WD3=0.

Fill acceptance:
- fill_ready = !hold_valid && count≠0.
- An accepted fill pops the queue head.
- If the pipeline owns the port that cycle, the fill is captured in the hold register.

Register x0:
- Any write with rd=0 drives WE3=0.
- A miss with rd=0 is still queued so fills stay aligned, but it never causes a stall.

stall = (rs1≠0 and rs1 matches any valid queue entry or hold_rd) OR (rs2≠0 and rs2 matches likewise). The logic is purely combinational.

Boundary conditions:
- miss_issue while full and no pop that cycle: the issue is ignored and err is set.
- fill_valid with count=0 and !hold_valid: ignored, err set.
- Simultaneous pop and push on a full queue: legal, count unchanged.
- Pointers wrap modulo DEPTH.
- A pipeline WAW to a pending rd is not checked. Upstream prevents it via stall.

## Timing
- Reset, asynchronous: count=0, both pointers 0, hold_valid=0, hold_rd=0, hold_data=0, err=0.
- Reset outputs: WE3=0, A3=0, WD3=0, stall=0, miss_full=0, fill_ready=0.
- A reset asserted mid-operation discards all pending entries and held data.
- Zero-latency write path: a source valid in cycle N writes the register file at the edge ending N.
- A fill accepted in cycle N with a free port: the entry is removed at the edge ending N; stall for that rd drops in N+1; the asynchronous register-file read in N+1 returns the new data.
- A fill accepted in cycle N while the pipeline writes: held in N+1, written at the edge ending N+1 unless another pipeline write arrives. stall for that rd stays high until the hold drains.
- A miss_issue in cycle N is visible to stall from N+1. The decode logic is responsible for the same-cycle case.

## Structure
- Shared package riscv_pkg: XLEN=32, REG_ADDR_W=5, and the typedef reg_idx_t.
- Sub-module wb_miss_queue: the DEPTH-entry rd FIFO. It exposes a head rd, per-entry valid/rd match vectors for two compare ports, full and empty flags, and push/pop.
- Top level contains the hold register, port mux, stall compare and err.

## Test plan
- Reset, then pipe_we=1, pipe_rd=5, pipe_wd=0xDEADBEEF → WE3=1, A3=5, WD3=0xDEADBEEF in the same cycle; stall=0.
- miss_issue rd=7; next cycle rs1=7 → stall=1. fill_valid with 0x1234 and no pipe_we → WE3=1, A3=7, WD3=0x1234; stall=0 the following cycle.
- Collision:
  - Setup: miss rd=3 pending.
  - Stimulus: fill 0xAA in the same cycle as pipe_we rd=4 with 0xBB.
  - Required: cycle N shows A3=4, WD3=0xBB, fill_ready=1. Cycle N+1 shows A3=3, WD3=0xAA, with fill_ready=0 in N+1. rs2=3 stalls through N+1.
- Misses rd=1 then rd=2 (full, DEPTH=2) → miss_full=1. A third miss_issue → err=1 and the queue is unchanged. Fills 0x11 and 0x22 → writes to x1 then x2, in order.
- Miss rd=0 followed by rs1=0 → stall=0. Its fill → WE3=0 and the queue is empty afterwards. A fill_valid with the queue empty → err=1.
- Assert rst low with two misses pending and the hold register valid → all outputs 0 immediately. After release, rs1=1 → stall=0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared core-wide widths and register index type.
package riscv_pkg;
  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_ADDR_W = 5;

  typedef logic [REG_ADDR_W-1:0] reg_idx_t;
endpackage

// File: rtl/wb_miss_queue.sv
// In-order FIFO of destination registers for outstanding load misses,
// with per-entry match vectors for the two decode source ports.
module wb_miss_queue
  import riscv_pkg::*;
#(
  parameter int unsigned ADDR  = REG_ADDR_W,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [ADDR-1:0]  push_rd,
  input  logic             pop,
  input  logic [ADDR-1:0]  cmp_a,
  input  logic [ADDR-1:0]  cmp_b,
  output logic [ADDR-1:0]  head_rd,
  output logic [DEPTH-1:0] match_a,
  output logic [DEPTH-1:0] match_b,
  output logic             full,
  output logic             empty
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [ADDR-1:0]  rd_q [DEPTH];
  logic [PW-1:0]    rptr_q, rptr_d, wptr_q, wptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok, pop_ok;
  logic [DEPTH-1:0] ent_valid;
  logic [PW-1:0]    off;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign pop_ok  = pop && !empty;
  // A push on a full queue is legal only when the head leaves the same cycle.
  assign push_ok = push && (!full || pop_ok);
  assign head_rd = rd_q[rptr_q];

  always_comb begin
    rptr_d  = rptr_q;
    wptr_d  = wptr_q;
    count_d = count_q;
    if (pop_ok)  rptr_d = rptr_q + PW'(1);
    if (push_ok) wptr_d = wptr_q + PW'(1);
    if (push_ok && !pop_ok)      count_d = count_q + CW'(1);
    else if (pop_ok && !push_ok) count_d = count_q - CW'(1);
  end

  // An entry is live when its distance from the head is below count.
  always_comb begin
    ent_valid = '0;
    match_a   = '0;
    match_b   = '0;
    off       = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      off          = PW'(i) - rptr_q;
      ent_valid[i] = (CW'(off) < count_q);
      match_a[i]   = ent_valid[i] && (rd_q[i] == cmp_a);
      match_b[i]   = ent_valid[i] && (rd_q[i] == cmp_b);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) rd_q[i] <= '0;
    end else begin
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      count_q <= count_d;
      if (push_ok) rd_q[wptr_q] <= push_rd;
    end
  end
endmodule

// File: rtl/writeback_arbiter.sv
// Merges pipeline writebacks and late miss fills onto the single register-file
// write port, and stalls decode on reads of registers still awaiting fill data.
module writeback_arbiter
  import riscv_pkg::*;
#(
  parameter int unsigned WIDTH = XLEN,
  parameter int unsigned ADDR  = REG_ADDR_W,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pipe_we,
  input  logic [ADDR-1:0]  pipe_rd,
  input  logic [WIDTH-1:0] pipe_wd,
  input  logic             miss_issue,
  input  logic [ADDR-1:0]  miss_rd,
  output logic             miss_full,
  input  logic             fill_valid,
  input  logic [WIDTH-1:0] fill_data,
  output logic             fill_ready,
  input  logic [ADDR-1:0]  rs1,
  input  logic [ADDR-1:0]  rs2,
  output logic             stall,
  output logic             WE3,
  output logic [ADDR-1:0]  A3,
  output logic [WIDTH-1:0] WD3,
  output logic             err
);
  logic             hold_valid_q, hold_valid_d;
  logic [ADDR-1:0]  hold_rd_q, hold_rd_d;
  logic [WIDTH-1:0] hold_data_q, hold_data_d;
  logic             err_q, err_d;
  logic             pipe_wr, fill_acc;
  logic [ADDR-1:0]  head_rd;
  logic [DEPTH-1:0] match_a, match_b;
  logic             q_full, q_empty;
  logic             hit1, hit2;

  wb_miss_queue #(.ADDR(ADDR), .DEPTH(DEPTH)) u_queue (
    .clk     (clk),
    .rst     (rst),
    .push    (miss_issue),
    .push_rd (miss_rd),
    .pop     (fill_acc),
    .cmp_a   (rs1),
    .cmp_b   (rs2),
    .head_rd (head_rd),
    .match_a (match_a),
    .match_b (match_b),
    .full    (q_full),
    .empty   (q_empty)
  );

  assign pipe_wr    = pipe_we && (pipe_rd != '0);
  assign fill_ready = !hold_valid_q && !q_empty;
  assign fill_acc   = fill_valid && fill_ready;
  assign miss_full  = q_full;
  assign err        = err_q;

  // Write-port mux: pipeline, then held fill, then direct fill; x0 never writes.
  always_comb begin
    WE3 = 1'b0;
    A3  = '0;
    WD3 = '0;
    if (pipe_wr) begin
      WE3 = 1'b1;
      A3  = pipe_rd;
      WD3 = pipe_wd;
    end else if (hold_valid_q) begin
      if (hold_rd_q != '0) begin
        WE3 = 1'b1;
        A3  = hold_rd_q;
        WD3 = hold_data_q;
      end
    end else if (fill_acc && (head_rd != '0)) begin
      WE3 = 1'b1;
      A3  = head_rd;
      WD3 = fill_data;
    end
  end

  always_comb begin
    hold_valid_d = hold_valid_q;
    hold_rd_d    = hold_rd_q;
    hold_data_d  = hold_data_q;
    err_d        = err_q;
    if (hold_valid_q && !pipe_wr) hold_valid_d = 1'b0;
    if (fill_acc && pipe_wr) begin
      hold_valid_d = 1'b1;
      hold_rd_d    = head_rd;
      hold_data_d  = fill_data;
    end
    if (miss_issue && q_full && !fill_acc)        err_d = 1'b1;
    if (fill_valid && q_empty && !hold_valid_q)   err_d = 1'b1;
  end

  assign hit1  = (rs1 != '0) && ((|match_a) || (hold_valid_q && (hold_rd_q == rs1)));
  assign hit2  = (rs2 != '0) && ((|match_b) || (hold_valid_q && (hold_rd_q == rs2)));
  assign stall = hit1 || hit2;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_valid_q <= 1'b0;
      hold_rd_q    <= '0;
      hold_data_q  <= '0;
      err_q        <= 1'b0;
    end else begin
      hold_valid_q <= hold_valid_d;
      hold_rd_q    <= hold_rd_d;
      hold_data_q  <= hold_data_d;
      err_q        <= err_d;
    end
  end
endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed self-checking bench for writeback_arbiter (DEPTH=2).
module tb_writeback_arbiter;
  logic        clk, rst;
  logic        pipe_we, miss_issue, fill_valid;
  logic [4:0]  pipe_rd, miss_rd, rs1, rs2;
  logic [31:0] pipe_wd, fill_data;
  logic        miss_full, fill_ready, stall, WE3, err;
  logic [4:0]  A3;
  logic [31:0] WD3;
  int          tests = 0;
  int          fails = 0;

  writeback_arbiter dut (
    .clk(clk), .rst(rst),
    .pipe_we(pipe_we), .pipe_rd(pipe_rd), .pipe_wd(pipe_wd),
    .miss_issue(miss_issue), .miss_rd(miss_rd), .miss_full(miss_full),
    .fill_valid(fill_valid), .fill_data(fill_data), .fill_ready(fill_ready),
    .rs1(rs1), .rs2(rs2), .stall(stall),
    .WE3(WE3), .A3(A3), .WD3(WD3), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    pipe_we = 0; pipe_rd = 0; pipe_wd = 0;
    miss_issue = 0; miss_rd = 0;
    fill_valid = 0; fill_data = 0;
    rs1 = 0; rs2 = 0;
  endtask

  task automatic chk_port(input string tag, input logic we, input logic [4:0] a, input logic [31:0] d);
    chk({tag, "_we"}, 32'(WE3), 32'(we));
    chk({tag, "_a3"}, 32'(A3), 32'(a));
    chk({tag, "_wd"}, WD3, d);
  endtask

  initial begin
    rst = 0;
    quiet();
    #2;
    chk_port("rst", 0, 0, 0);
    chk("rst_stall", 32'(stall), 0);
    chk("rst_full", 32'(miss_full), 0);
    chk("rst_ready", 32'(fill_ready), 0);
    chk("rst_err", 32'(err), 0);
    #10 rst = 1;
    step();

    // plain pipeline writeback
    pipe_we = 1; pipe_rd = 5; pipe_wd = 32'hDEADBEEF; #1;
    chk_port("pipe", 1, 5, 32'hDEADBEEF);
    chk("pipe_stall", 32'(stall), 0);
    step();

    // miss on x7, then direct fill
    quiet(); miss_issue = 1; miss_rd = 7; rs1 = 7; #1;
    chk("miss_same_cyc_stall", 32'(stall), 0);
    step();
    quiet(); rs1 = 7; #1;
    chk("miss7_stall", 32'(stall), 1);
    chk("miss7_ready", 32'(fill_ready), 1);
    step();
    fill_valid = 1; fill_data = 32'h1234; #1;
    chk_port("fill7", 1, 7, 32'h1234);
    chk("fill7_stall_cyc", 32'(stall), 1);
    step();
    fill_valid = 0; #1;
    chk("fill7_stall_after", 32'(stall), 0);
    chk("fill7_ready_after", 32'(fill_ready), 0);
    chk("fill7_we_after", 32'(WE3), 0);

    // collision: fill x3 with pipeline write to x4
    quiet(); miss_issue = 1; miss_rd = 3; #1;
    step();
    quiet(); rs2 = 3; fill_valid = 1; fill_data = 32'hAA;
    pipe_we = 1; pipe_rd = 4; pipe_wd = 32'hBB; #1;
    chk_port("coll_n", 1, 4, 32'hBB);
    chk("coll_n_ready", 32'(fill_ready), 1);
    chk("coll_n_stall", 32'(stall), 1);
    step();
    quiet(); rs2 = 3; #1;
    chk_port("coll_n1", 1, 3, 32'hAA);
    chk("coll_n1_ready", 32'(fill_ready), 0);
    chk("coll_n1_stall", 32'(stall), 1);
    step();
    #1;
    chk("coll_n2_stall", 32'(stall), 0);
    chk("coll_n2_we", 32'(WE3), 0);

    // fill queue, push+pop on full, overflow, in-order drain
    quiet(); miss_issue = 1; miss_rd = 1; #1;
    step();
    miss_rd = 2; #1;
    step();
    quiet(); #1;
    chk("full2", 32'(miss_full), 1);
    fill_valid = 1; fill_data = 32'h11; miss_issue = 1; miss_rd = 6; #1;
    chk_port("fill1_pushpop", 1, 1, 32'h11);
    step();
    quiet(); rs1 = 6; rs2 = 1; #1;
    chk("pushpop_full", 32'(miss_full), 1);
    chk("pushpop_err", 32'(err), 0);
    chk("pushpop_stall6", 32'(stall), 1);
    rs1 = 0; #1;
    chk("pushpop_x1_gone", 32'(stall), 0);
    quiet(); miss_issue = 1; miss_rd = 9; #1;
    step();
    quiet(); rs1 = 9; #1;
    chk("ovf_err", 32'(err), 1);
    chk("ovf_not_queued", 32'(stall), 0);
    chk("ovf_full", 32'(miss_full), 1);
    quiet(); fill_valid = 1; fill_data = 32'h22; #1;
    chk_port("fill2", 1, 2, 32'h22);
    step();
    fill_data = 32'h66; #1;
    chk_port("fill6", 1, 6, 32'h66);
    step();
    quiet(); #1;
    chk("drain_full", 32'(miss_full), 0);
    chk("drain_ready", 32'(fill_ready), 0);

    // mid-operation reset with two misses pending and hold valid
    miss_issue = 1; miss_rd = 1; #1;
    step();
    miss_rd = 2; #1;
    step();
    quiet(); fill_valid = 1; fill_data = 32'h55; pipe_we = 1; pipe_rd = 4; pipe_wd = 32'h44; #1;
    step();
    quiet(); pipe_we = 1; pipe_rd = 4; pipe_wd = 32'h44; miss_issue = 1; miss_rd = 3; #1;
    step();
    quiet(); rs1 = 1; rs2 = 2; #1;
    chk("pre_rst_hold_we", 32'(WE3), 1);
    chk("pre_rst_hold_a3", 32'(A3), 1);
    chk("pre_rst_full", 32'(miss_full), 1);
    rst = 0; #1;
    chk_port("async_rst", 0, 0, 0);
    chk("async_rst_stall", 32'(stall), 0);
    chk("async_rst_full", 32'(miss_full), 0);
    chk("async_rst_ready", 32'(fill_ready), 0);
    chk("async_rst_err", 32'(err), 0);
    step();
    rst = 1;
    step();
    quiet(); rs1 = 1; #1;
    chk("post_rst_stall", 32'(stall), 0);
    chk("post_rst_ready", 32'(fill_ready), 0);

    // miss to x0: queued but never stalls or writes
    quiet(); miss_issue = 1; miss_rd = 0; #1;
    step();
    quiet(); #1;
    chk("x0_stall", 32'(stall), 0);
    chk("x0_ready", 32'(fill_ready), 1);
    fill_valid = 1; fill_data = 32'h77; #1;
    chk("x0_fill_we", 32'(WE3), 0);
    step();
    quiet(); #1;
    chk("x0_empty_ready", 32'(fill_ready), 0);
    chk("x0_err_clean", 32'(err), 0);
    fill_valid = 1; fill_data = 32'h88; #1;
    chk("empty_fill_we", 32'(WE3), 0);
    step();
    quiet(); #1;
    chk("empty_fill_err", 32'(err), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
